rr_lock_arbiter: RTL
====================

// Module: rr_lock_arbiter
// PURPOSE
//   N-way round-robin arbiter with grant locking for one shared resource
//   (bus / memory port). The owner keeps the grant until it signals done,
//   drops its request, or exceeds a hold limit. Grants are mutually
//   exclusive, with one dead cycle between owners. Sits between requesting
//   masters and the resource mux, which it steers with gnt_id.
// PARAMETERS
//   N_REQ     4    number of requesters, >=2
//   HOLD_MAX  16   max consecutive grant cycles per ownership, >=1
//   ID_W      2    width of gnt_id, = clog2(N_REQ); fixed, not an override
// PORTS
//   clk      in   1      rising-edge clock
//   reset    in   1      synchronous, active-high reset
//   req      in   N_REQ  request level per requester
//   done     in   N_REQ  one-cycle release pulse per requester
//   gnt      out  N_REQ  one-hot grant, or all-zero
//   gnt_id   out  ID_W   index of current or last owner
//   busy     out  1      1 while any grant is asserted
//   timeout  out  1      one-cycle pulse on forced release
// BEHAVIOUR
//   - Reset: gnt=0, gnt_id=0, busy=0, timeout=0, ptr=0, hold_cnt=0,
//     state=IDLE. Asserting reset mid-grant clears gnt on that edge.
//   - All outputs are registered.
//   - FSM has two states, IDLE and GRANT.
//   - IDLE: on an edge with |req, pick the first set req[i] searching
//     i = ptr, ptr+1, ... mod N_REQ (wraps). Then gnt<=onehot(i),
//     gnt_id<=i, busy<=1, hold_cnt<=0, go to GRANT.
//     Latency is 1 cycle from sampled req to visible gnt.
//   - GRANT (owner o): hold_cnt increments each cycle. Release at the edge
//     where any of these holds:
//     (a) done[o]=1;
//     (b) req[o]=0;
//     (c) hold_cnt==HOLD_MAX-1, i.e. the owner had gnt for HOLD_MAX cycles.
//   - On release: gnt<=0, busy<=0, ptr<=(o+1) mod N_REQ, go to IDLE.
//     gnt_id keeps o. timeout<=1 only if (c) is the sole cause; (a) or (b)
//     take priority and give timeout=0.
//   - After a release, gnt is zero for at least 1 cycle. The next grant is
//     visible 2 cycles after the release edge at the earliest.
//   - done[j] for j!=o is ignored, as is done in IDLE.
//   - req changes of non-owners during GRANT do not affect the owner.
//   - A timed-out owner still requesting is re-eligible, but others win
//     first because ptr advanced.
//   - A single requester re-requesting gets re-granted after one gap cycle.
//   - Invariants checked every cycle: $onehot0(gnt);
//     busy == |gnt; gnt != 0 implies gnt[gnt_id]==1.
// STRUCTURE
//   - rr_arb_defs.vh holds localparams for the state encoding
//     (ST_IDLE=1'b0, ST_GRANT=1'b1) and the clog2 function. Shared with
//     future arbiters.
//   - Sub-module rr_pick (combinational): inputs req[N_REQ] and ptr[ID_W];
//     outputs valid and idx[ID_W], the first set bit at or after ptr with
//     wrap. Implement as a doubled-vector priority encoder.
//   - Top level holds the FSM, ptr, hold_cnt (width clog2(HOLD_MAX+1)) and
//     the output registers.
// TESTING (N_REQ=4, HOLD_MAX=4 unless noted)
//   - Every test: the bench asserts the invariants each posedge and fails
//     on any violation.
//   1. Reset: req=4'b1111 during 3 reset cycles -> gnt=0, busy=0
//      throughout; 1 cycle after reset drops, gnt=4'b0001, gnt_id=0.
//   2. Rotation: req=4'b1111 held, done[owner] pulsed 2nd cycle of each
//      grant -> gnt sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001
//      (ptr wraps); timeout stays 0.
//   3. Timeout: only req[2] held, no done -> gnt=0100 for exactly 4 cycles;
//      timeout=1 for 1 cycle as gnt drops; regrant 0100 after 1 gap cycle.
//   4. Priority: done[o] and hold_cnt==3 on the same edge -> release with
//      timeout=0. req[o] dropped mid-grant -> gnt=0 next edge, timeout=0.
//   5. Ignore: done[3] pulsed while gnt=0001, and done pulsed in IDLE ->
//      no grant change; ptr unchanged by ignored pulses.
//   6. Reset mid-grant: gnt=0010 at hold_cnt=2, reset for 1 cycle ->
//      gnt=0, ptr=0; with req=1111 the next grant is 0001, not 0100.

Source files
------------

// File: rtl/rr_lock_arbiter_pkg.sv
// Shared definitions for the round-robin lock arbiters: state encoding and
// a constant-evaluable ceiling log2.
package rr_lock_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping, built as a priority encoder over a doubled request vector.
module rr_pick
    import rr_lock_arbiter_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             valid,
    output logic [ID_W-1:0]  idx
);

    localparam int unsigned DBL_W = 2 * N_REQ;
    localparam int unsigned SUM_W = ID_W + 1;

    logic [DBL_W-1:0] dbl;
    logic [N_REQ-1:0] rot;
    logic [ID_W-1:0]  off;
    logic [SUM_W-1:0] sum;

    always_comb begin
        dbl   = {req, req};
        rot   = N_REQ'(dbl >> ptr);
        valid = |req;
        off   = '0;
        // Descending scan so the lowest rotated position wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = ID_W'(i);
            end
        end
        sum = SUM_W'(ptr) + SUM_W'(off);
        if (sum >= SUM_W'(N_REQ)) begin
            idx = ID_W'(sum - SUM_W'(N_REQ));
        end else begin
            idx = ID_W'(sum);
        end
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// N-way round-robin arbiter with grant locking: the owner holds the resource
// until done, request drop, or the hold limit, with one dead cycle between owners.
module rr_lock_arbiter
    import rr_lock_arbiter_pkg::*;
#(
    parameter  int unsigned N_REQ    = 4,
    parameter  int unsigned HOLD_MAX = 16,
    localparam int unsigned ID_W     = clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             timeout
);

    localparam int unsigned HC_W = clog2(HOLD_MAX + 1);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;

    logic             pick_valid;
    logic [ID_W-1:0]  pick_idx;
    logic             rel_done, rel_drop, rel_hold;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state and registered-output logic; gnt_id_q names the owner in GRANT.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        rel_done   = done[gnt_id_q];
        rel_drop   = ~req[gnt_id_q];
        rel_hold   = (hold_cnt_q == HC_W'(HOLD_MAX - 1));

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_d      = N_REQ'(1) << pick_idx;
                    gnt_id_d   = pick_idx;
                    busy_d     = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (rel_done || rel_drop || rel_hold) begin
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                    timeout_d = rel_hold && !rel_done && !rel_drop;
                    ptr_d     = (gnt_id_q == ID_W'(N_REQ - 1)) ? '0 : gnt_id_q + ID_W'(1);
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule
